// File: rtl/hvac_drive_if.sv
// hvac_drive_if
// Bundles the thermostat demand bits and the actuator/status outputs of
// hvac_drive into one interface.
//
// Signal semantics: heating/cooling are plain level demands, sampled on
// every rising clock edge. There is no valid/ready handshake and no
// backpressure. The drive consumes whatever level is present at each edge.
// All outputs are registered and change only just after a rising edge.
//
// Modports:
//   master : the demand source (thermostat or bench) drives heating/cooling
//            and observes the actuator and status outputs
//   slave  : hvac_drive samples heating/cooling and drives
//            heater_on, compressor_on, fan_on, state and conflict
interface hvac_drive_if;
    logic       heating;
    logic       cooling;
    logic       heater_on;
    logic       compressor_on;
    logic       fan_on;
    logic [1:0] state;
    logic       conflict;

    modport master (
        output heating,
        output cooling,
        input  heater_on,
        input  compressor_on,
        input  fan_on,
        input  state,
        input  conflict
    );

    modport slave (
        input  heating,
        input  cooling,
        output heater_on,
        output compressor_on,
        output fan_on,
        output state,
        output conflict
    );
endinterface

// File: rtl/hvac_drive.sv
// hvac_drive
// Actuator stage behind the thermostat. It turns heating/cooling demand
// levels into heater, compressor and fan drive, and protects the plant
// against short-cycling. The protection has three parts:
//   - Every run lasts at least MIN_ON cycles.
//   - After every run there is a rest of exactly MIN_OFF cycles.
//   - The fan keeps running for the first FAN_OVERRUN cycles of the rest.
// A changeover between heat and cool always goes through REST and IDLE.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset; shuts everything down at once
//   bus  : hvac_drive_if.slave
//            heating, cooling            demand levels in
//            heater_on, compressor_on    contactor drives out
//            fan_on                      blower drive out
//            state                       IDLE=0 HEAT=1 COOL=2 REST=3
//            conflict                    both demands were high at last edge
module hvac_drive #(
    parameter int MIN_ON      = 8,
    parameter int MIN_OFF     = 6,
    parameter int FAN_OVERRUN = 4,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    hvac_drive_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2,
        REST = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);
    // The rest timer is compared one bit wider, so that a FAN_OVERRUN equal
    // to 2**CNT_W cannot wrap to zero.
    localparam logic [CNT_W:0]   FAN_LIM  = (CNT_W+1)'(FAN_OVERRUN);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;
    logic             conflict_q;
    logic             heater_q;
    logic             compressor_q;
    logic             fan_q;
    logic             fan_d;

    logic heat_req;
    logic cool_req;

    // Both demands high at once is treated as no request at all.
    assign heat_req = bus.heating & ~bus.cooling;
    assign cool_req = bus.cooling & ~bus.heating;

    // Next-state and next-timer logic. The outputs are registered from these
    // values, so each output appears in the same cycle as the state it
    // belongs to. No input reaches an output without passing a flop.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (heat_req) begin
                    state_d = HEAT;
                end else if (cool_req) begin
                    state_d = COOL;
                end
            end
            HEAT: begin
                if (timer_q == ON_LAST) begin
                    // The timer stays saturated while the demand persists.
                    if (!heat_req) begin
                        state_d = REST;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            COOL: begin
                if (timer_q == ON_LAST) begin
                    if (!cool_req) begin
                        state_d = REST;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REST: begin
                // The rest period ignores demand entirely.
                if (timer_q == OFF_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign fan_d = (state_d == HEAT) || (state_d == COOL) ||
                   ((state_d == REST) && ({1'b0, timer_d} < FAN_LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            conflict_q   <= 1'b0;
            heater_q     <= 1'b0;
            compressor_q <= 1'b0;
            fan_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            conflict_q   <= bus.heating & bus.cooling;
            // The heater and compressor cannot both be on, because each one
            // decodes a different state.
            heater_q     <= (state_d == HEAT);
            compressor_q <= (state_d == COOL);
            fan_q        <= fan_d;
        end
    end

    assign bus.heater_on     = heater_q;
    assign bus.compressor_on = compressor_q;
    assign bus.fan_on        = fan_q;
    assign bus.state         = state_q;
    assign bus.conflict      = conflict_q;

endmodule

// File: doc/hvac_drive.md
# hvac_drive

Actuator stage downstream of the `ac` thermostat controller. Consumes its `heating`/`cooling` demand bits and drives the physical heater, compressor and fan, enforcing a minimum run time, a minimum rest time between runs, and a fan overrun after every run. Protects plant from short-cycling when the thermostat output chatters near the 18/22 thresholds.

## Interface
- `MIN_ON`, 8: minimum cycles heater/compressor stay on once started (>=1)
- `MIN_OFF`, 6: rest cycles after any run before a new run may start (>=1)
- `FAN_OVERRUN`, 4: cycles fan stays on at start of rest (0..MIN_OFF)
- `CNT_W`, 8: timer width; must hold max(MIN_ON, MIN_OFF)-1

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `heating`  in  1  heat demand from `ac`
- `cooling`  in  1  cool demand from `ac`
- `heater_on`  out  1  heater contactor
- `compressor_on`  out  1  compressor contactor
- `fan_on`  out  1  blower
- `state`  out  2  current state: IDLE=0, HEAT=1, COOL=2, REST=3
- `conflict`  out  1  registered flag: both demands were high at last edge

## Operation
- Registers: 2-bit state, CNT_W-bit timer, conflict flag. Outputs decoded from state/timer registers only; no combinational input-to-output path.
- Valid heat request = `heating & ~cooling`; valid cool request = `cooling & ~heating`. Both high = no valid request; `conflict` set to 1 for that cycle (recomputed every edge, not sticky).
- IDLE: all actuators 0. Valid heat -> HEAT; valid cool -> COOL; otherwise stay. Timer cleared on entry to HEAT/COOL.
- HEAT: `heater_on`=1, `fan_on`=1. Timer increments, saturating at MIN_ON-1. When timer==MIN_ON-1 and valid heat request absent -> REST (timer cleared). Request loss before then ignored.
- COOL: as HEAT with `compressor_on`.
- REST: heater/compressor 0; `fan_on`=1 while timer<FAN_OVERRUN. Timer increments; at timer==MIN_OFF-1 -> IDLE regardless of requests.
- No direct HEAT<->COOL transition; changeover always passes REST then IDLE.
- `heater_on` and `compressor_on` never both 1 (structural: one-hot by state).

## Timing
- Reset: at the rising edge with `rst`=1, state=IDLE, timer=0, conflict=0; all outputs 0 from that edge. Reset overrides min-on/min-off mid-run (immediate shutdown, no fan overrun).
- Start latency: valid request sampled at edge k -> actuator high after edge k (1 cycle from request setup to output).
- Run length: min MIN_ON cycles; if request held, output drops one cycle after the edge sampling request loss (earliest at edge after MIN_ON cycles in state).
- Rest length: exactly MIN_OFF cycles, then at least 1 IDLE cycle. Minimum gap between run end and next run start: MIN_OFF+1 cycles.
- Fan: high for entire run plus first FAN_OVERRUN rest cycles; FAN_OVERRUN=0 -> fan drops with actuator.
- Timer saturates; never wraps in any state.
- `conflict` valid one cycle after sampled edge, independent of state.

## Test plan
- Reset: `rst`=1 two cycles with `heating`=1 -> all outputs 0, `state`=0; release `rst` with `heating`=1 -> `state`=1, `heater_on`=1 after next edge.
- Short pulse: `heating`=1 for one edge from IDLE -> `heater_on`=1 exactly 8 cycles, then REST 6 cycles with `fan_on`=1 first 4, then `state`=0, all 0.
- Held demand: `cooling`=1 for 20 edges -> `compressor_on`=1 for 20 cycles, drops one cycle after `cooling` falls; `heater_on` stays 0 throughout.
- Changeover: `heating` 1 cycle then `cooling`=1 continuously -> `compressor_on` rises 15 cycles after `heater_on` rose (8 HEAT + 6 REST + 1 IDLE), never overlapping `heater_on`.
- Conflict: both high in IDLE 3 cycles -> stays IDLE, `conflict`=1 for 3 cycles; both high in HEAT after 8 cycles -> REST next edge.
- Mid-run reset: `rst`=1 at HEAT timer=3 -> `heater_on`=`fan_on`=0 and `state`=0 after that edge; no REST phase.
